// File: rtl/fetch_unit_if.sv
// Program-memory read port and instruction-issue handshake of the fetch unit.
interface fetch_unit_if #(
    parameter int unsigned ADDR_W = 5
);
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_rdata;
    logic              mem_ready;
    logic [2:0]        Opcode;
    logic [4:0]        Operand;
    logic              instr_valid;
    logic              instr_ack;

    // Fetch unit side: drives the memory request and the issued instruction.
    modport master (
        output mem_req,
        output mem_addr,
        input  mem_rdata,
        input  mem_ready,
        output Opcode,
        output Operand,
        output instr_valid,
        input  instr_ack
    );

    // Memory/controller side.
    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_rdata,
        output mem_ready,
        input  Opcode,
        input  Operand,
        input  instr_valid,
        output instr_ack
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch unit: reads 8-bit words from program memory, issues them
// to the controller and advances the program counter (HLT/JMP/SKZ aware).
module fetch_unit #(
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              Load_in,
    fetch_unit_if.master      bus,
    input  logic              zero_flag,
    output logic [ADDR_W-1:0] pc,
    output logic              halted
);
    localparam int unsigned INSTR_W = 8;
    localparam int unsigned OPC_W   = 3;
    localparam int unsigned OPD_W   = 5;

    localparam logic [OPC_W-1:0] OP_HLT = 3'b000;
    localparam logic [OPC_W-1:0] OP_SKZ = 3'b001;
    localparam logic [OPC_W-1:0] OP_JMP = 3'b111;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        ISSUE,
        HALT
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [INSTR_W-1:0]  ir_q, ir_d;
    logic                mem_req_q;
    logic                instr_valid_q;
    logic                halted_q;

    logic [OPC_W-1:0]    ir_opc;
    logic [OPD_W-1:0]    ir_opd;

    assign ir_opc = ir_q[INSTR_W-1:OPD_W];
    assign ir_opd = ir_q[OPD_W-1:0];

    // Next-state, next-pc and instruction capture; Load_in overrides everything.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        if (Load_in) begin
            state_d = IDLE;
            pc_d    = '0;
        end else begin
            case (state_q)
                IDLE: state_d = FETCH;
                FETCH: begin
                    if (bus.mem_ready) begin
                        ir_d    = bus.mem_rdata;
                        state_d = ISSUE;
                    end
                end
                ISSUE: begin
                    if (ir_opc == OP_HLT) begin
                        state_d = HALT;
                    end else if (bus.instr_ack) begin
                        state_d = FETCH;
                        case (ir_opc)
                            OP_JMP:  pc_d = ADDR_W'(ir_opd);
                            OP_SKZ:  pc_d = pc_q + (zero_flag ? ADDR_W'(2) : ADDR_W'(1));
                            default: pc_d = pc_q + ADDR_W'(1);
                        endcase
                    end
                end
                HALT:    state_d = HALT;
                default: state_d = IDLE;
            endcase
        end
    end

    // State, pc, instruction register and registered status outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            pc_q          <= '0;
            ir_q          <= '0;
            mem_req_q     <= 1'b0;
            instr_valid_q <= 1'b0;
            halted_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            ir_q          <= ir_d;
            mem_req_q     <= (state_d == FETCH);
            instr_valid_q <= (state_d == ISSUE);
            halted_q      <= (state_d == HALT);
        end
    end

    assign bus.mem_req     = mem_req_q;
    assign bus.mem_addr    = pc_q;
    assign bus.Opcode      = ir_opc;
    assign bus.Operand     = ir_opd;
    assign bus.instr_valid = instr_valid_q;
    assign pc              = pc_q;
    assign halted          = halted_q;
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus randomized instruction stream
// checked against an architectural pc/issue model.
module tb_fetch_unit;
    localparam int unsigned ADDR_W = 5;
    localparam int PC_MOD = 1 << ADDR_W;

    logic              clock;
    logic              reset;
    logic              Load_in;
    logic              zero_flag;
    logic [ADDR_W-1:0] pc;
    logic              halted;
    logic [7:0]        mem_arr [0:PC_MOD-1];

    int n_cmp = 0;
    int n_err = 0;
    int mpc   = 0;

    fetch_unit_if #(.ADDR_W(ADDR_W)) bus ();

    fetch_unit #(.ADDR_W(ADDR_W)) dut (
        .clock     (clock),
        .reset     (reset),
        .Load_in   (Load_in),
        .bus       (bus),
        .zero_flag (zero_flag),
        .pc        (pc),
        .halted    (halted)
    );

    assign bus.mem_rdata = mem_arr[bus.mem_addr];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_req();
        int n = 0;
        while (bus.mem_req !== 1'b1 && n < 20) begin
            @(negedge clock);
            n++;
        end
        check("req_timeout", bus.mem_req, 1);
    endtask

    // One instruction end to end: memory wait rdly cycles, ack withheld adly cycles.
    task automatic run_instr(input int rdly, input int adly, input bit zf);
        logic [7:0] w;
        int op;
        int opd;
        wait_req();
        w   = mem_arr[mpc];
        op  = int'(w[7:5]);
        opd = int'(w[4:0]);
        check("fetch_addr", bus.mem_addr, mpc);
        check("fetch_valid_lo", bus.instr_valid, 0);
        for (int i = 0; i < rdly; i++) begin
            bus.instr_ack = 1'b1;
            @(negedge clock);
            check("wait_req_hi", bus.mem_req, 1);
            check("wait_addr", bus.mem_addr, mpc);
            check("wait_valid_lo", bus.instr_valid, 0);
        end
        bus.instr_ack = 1'b0;
        bus.mem_ready = 1'b1;
        @(negedge clock);
        bus.mem_ready = 1'b0;
        check("issue_valid", bus.instr_valid, 1);
        check("issue_opcode", bus.Opcode, op);
        check("issue_operand", bus.Operand, opd);
        check("issue_req_lo", bus.mem_req, 0);
        if (op == 0) begin
            @(negedge clock);
            check("hlt_halted", halted, 1);
            check("hlt_valid_lo", bus.instr_valid, 0);
            check("hlt_pc", pc, mpc);
            return;
        end
        for (int i = 0; i < adly; i++) begin
            @(negedge clock);
            check("hold_valid", bus.instr_valid, 1);
            check("hold_opcode", bus.Opcode, op);
            check("hold_operand", bus.Operand, opd);
            check("hold_pc", pc, mpc);
        end
        bus.instr_ack = 1'b1;
        zero_flag     = zf;
        @(negedge clock);
        bus.instr_ack = 1'b0;
        case (op)
            7:       mpc = opd % PC_MOD;
            1:       mpc = (mpc + (zf ? 2 : 1)) % PC_MOD;
            default: mpc = (mpc + 1) % PC_MOD;
        endcase
        check("next_pc", pc, mpc);
        check("next_valid_lo", bus.instr_valid, 0);
        check("next_req_hi", bus.mem_req, 1);
    endtask

    initial begin
        reset         = 1'b0;
        Load_in       = 1'b0;
        zero_flag     = 1'b0;
        bus.mem_ready = 1'b0;
        bus.instr_ack = 1'b0;
        for (int i = 0; i < PC_MOD; i++) mem_arr[i] = 8'h40;

        // Reset values
        #1;
        check("rst_req", bus.mem_req, 0);
        check("rst_valid", bus.instr_valid, 0);
        check("rst_halted", halted, 0);
        check("rst_pc", pc, 0);
        check("rst_opcode", bus.Opcode, 0);
        check("rst_operand", bus.Operand, 0);

        // Two plain instructions from address 0
        mem_arr[0] = 8'h45;
        mem_arr[1] = 8'hC3;
        @(negedge clock);
        reset = 1'b1;
        mpc   = 0;
        run_instr(0, 0, 1'b0);
        run_instr(0, 0, 1'b0);
        check("seq_pc2", pc, 2);

        // JMP 9 at pc 4
        mem_arr[2] = 8'h40;
        mem_arr[3] = 8'h60;
        mem_arr[4] = 8'hE9;
        run_instr(0, 0, 1'b0);
        run_instr(1, 0, 1'b0);
        run_instr(0, 1, 1'b0);
        check("jmp_pc9", pc, 9);
        check("jmp_addr9", bus.mem_addr, 9);

        // SKZ wrap cases around the top of memory
        mem_arr[9]  = 8'hFE;
        mem_arr[30] = 8'h20;
        mem_arr[31] = 8'h20;
        run_instr(0, 0, 1'b0);
        run_instr(0, 0, 1'b1);
        check("skz30_z1", pc, 0);
        mem_arr[0] = 8'hFE;
        run_instr(0, 0, 1'b0);
        run_instr(0, 0, 1'b0);
        check("skz30_z0", pc, 31);
        run_instr(0, 0, 1'b1);
        check("skz31_z1", pc, 1);

        // Long memory wait and withheld ack
        mem_arr[1] = 8'h45;
        run_instr(5, 3, 1'b0);

        // Randomized instruction stream (no HLT)
        for (int k = 0; k < 24; k++) begin
            mem_arr[mpc] = {3'($urandom_range(1, 7)), 5'($urandom_range(0, 31))};
            run_instr(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'($urandom));
        end

        // HLT at pc 7, stays halted, Load_in pulse restarts at 0
        mem_arr[mpc] = 8'hE7;
        mem_arr[7]   = 8'h00;
        run_instr(0, 0, 1'b0);
        run_instr(0, 0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            check("halt_req_lo", bus.mem_req, 0);
            check("halt_hold", halted, 1);
        end
        Load_in = 1'b1;
        @(negedge clock);
        Load_in = 1'b0;
        check("load_halted_lo", halted, 0);
        check("load_pc0", pc, 0);
        check("load_req_lo", bus.mem_req, 0);
        @(negedge clock);
        check("resume_req", bus.mem_req, 1);
        check("resume_addr", bus.mem_addr, 0);

        // Load_in together with instr_ack: jump is dropped
        mem_arr[0] = 8'hE5;
        bus.mem_ready = 1'b1;
        @(negedge clock);
        bus.mem_ready = 1'b0;
        check("la_valid", bus.instr_valid, 1);
        Load_in       = 1'b1;
        bus.instr_ack = 1'b1;
        @(negedge clock);
        Load_in       = 1'b0;
        bus.instr_ack = 1'b0;
        check("la_pc0", pc, 0);
        check("la_valid_lo", bus.instr_valid, 0);
        check("la_req_lo", bus.mem_req, 0);

        // Load_in together with mem_ready, then reset mid-ISSUE
        mem_arr[0] = 8'h45;
        wait_req();
        Load_in       = 1'b1;
        bus.mem_ready = 1'b1;
        @(negedge clock);
        Load_in       = 1'b0;
        bus.mem_ready = 1'b0;
        check("lr_valid_lo", bus.instr_valid, 0);
        check("lr_req_lo", bus.mem_req, 0);
        check("lr_pc0", pc, 0);
        wait_req();
        check("lr_addr0", bus.mem_addr, 0);
        bus.mem_ready = 1'b1;
        @(negedge clock);
        bus.mem_ready = 1'b0;
        check("mid_issue_valid", bus.instr_valid, 1);
        #2;
        reset = 1'b0;
        #1;
        check("arst_req", bus.mem_req, 0);
        check("arst_valid", bus.instr_valid, 0);
        check("arst_halted", halted, 0);
        check("arst_pc", pc, 0);
        check("arst_opcode", bus.Opcode, 0);
        check("arst_operand", bus.Operand, 0);
        @(negedge clock);
        reset = 1'b1;
        mpc   = 0;
        run_instr(1, 1, 1'b0);
        check("post_rst_pc", pc, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter ADDR_W, default 5, program-memory address width; instruction word fixed at 8 bits ({opcode[2:0], operand[4:0]}) with ADDR_W >= 5.
REQ-002 clock  input  1  single system clock, all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 Load_in  input  1  program-load mode; high = memory owned by loader, fetch suspended.
REQ-005 mem_req  output  1  read request to program memory.
REQ-006 mem_addr  output  ADDR_W  read address, equals pc while mem_req high.
REQ-007 mem_rdata  input  8  instruction word, valid when mem_ready high.
REQ-008 mem_ready  input  1  read completion strobe, sampled only while mem_req high.
REQ-009 Opcode  output  3  issued opcode to controller.
REQ-010 Operand  output  5  issued operand / target address.
REQ-011 instr_valid  output  1  Opcode/Operand hold a live instruction.
REQ-012 instr_ack  input  1  controller accepted the issued instruction.
REQ-013 zero_flag  input  1  accumulator-zero status for SKZ.
REQ-014 pc  output  ADDR_W  current program counter.
REQ-015 halted  output  1  HLT executed, fetch stopped.

Function
REQ-016 FSM states IDLE, FETCH, ISSUE, HALT; exactly one active.
REQ-017 IDLE: all request/valid outputs low; next state FETCH when Load_in low.
REQ-018 FETCH: mem_req high, mem_addr = pc; stays until mem_ready high; on mem_ready, instruction register <= mem_rdata, next state ISSUE.
REQ-019 ISSUE: instr_valid high, Opcode/Operand = instruction register [7:5]/[4:0], held stable until instr_ack.
REQ-020 ISSUE with opcode 000 (HLT): no ack required; next cycle state HALT, halted high, pc unchanged, instr_valid low.
REQ-021 ISSUE with instr_ack and opcode 111 (JMP): pc <= Operand zero-extended to ADDR_W; next state FETCH.
REQ-022 ISSUE with instr_ack and opcode 001 (SKZ): pc <= pc+2 if zero_flag high at ack cycle, else pc+1; next state FETCH.
REQ-023 ISSUE with instr_ack, any other opcode: pc <= pc+1; next state FETCH.
REQ-024 PC arithmetic modulo 2^ADDR_W; 31+1 -> 0, 30+2 -> 0, 31+2 -> 1 (ADDR_W=5).
REQ-025 instr_ack while instr_valid low is ignored.
REQ-026 Fetch latency: mem_req asserted the cycle after entering FETCH; instr_valid asserted the cycle after mem_ready; minimum 2 cycles per instruction plus memory wait.
REQ-027 HALT: terminal until reset or Load_in high; mem_req and instr_valid low.
REQ-028 Load_in high in any state (synchronous, priority over all transitions): next cycle state IDLE, pc <= 0, instr_valid low, mem_req low, halted low; in-flight read discarded.
REQ-029 Load_in high same cycle as mem_ready or instr_ack: Load_in wins, instruction dropped, pc <= 0.
REQ-030 Load_in falling: FETCH entered on the following cycle, first fetch from address 0.

Reset
REQ-031 reset low asynchronously forces state IDLE, pc = 0, instruction register = 0, Opcode = 000, Operand = 0, mem_req = 0, instr_valid = 0, halted = 0.
REQ-032 After reset release, first fetch starts on the cycle following the first clock edge with Load_in low.
REQ-033 reset assertion mid-FETCH or mid-ISSUE aborts immediately; no partial pc update.

Verification
REQ-034 Reset, Load_in=0, mem holds 0x45,0xC3 at 0,1, ack each issue -> Opcode 010/Operand 5 then 110/Operand 3, pc 0 -> 1 -> 2.
REQ-035 Word 0xE9 (JMP 9) at pc 4, ack -> pc = 9, next mem_addr = 9.
REQ-036 SKZ (0x20) at pc 30: zero_flag=1 -> pc 0; zero_flag=0 -> pc 31; SKZ at 31 with zero_flag=1 -> pc 1.
REQ-037 mem_ready held low 5 cycles -> mem_req high, mem_addr stable, instr_valid low throughout; instr_ack withheld 3 cycles -> Opcode/Operand stable, pc unchanged.
REQ-038 Word 0x00 at pc 7 -> halted = 1, mem_req stays 0 for 10 cycles; Load_in pulse -> halted 0, pc 0, fetch resumes at 0.
REQ-039 Load_in raised same cycle as mem_ready, then reset pulsed low mid-ISSUE -> instruction dropped, pc = 0, all outputs at REQ-031 values within same cycle of reset.
